sram_burst_bridge: RTL and testbench
====================================

Name: sram_burst_bridge

Overview:
- Byte-stream to SRAM bridge between the UART rx/tx byte interfaces and a single-port SRAM macro.
- Successor of the fixed 32-bit/5-bit-address controller, parametrised in data width, address width and byte order.
- Adds multi-word bursts with address auto-increment, multi-byte addresses, registered SRAM strobes and an inter-byte timeout abort.

Parameters:
- DATA_BYTES, 4, bytes per SRAM word (1..8); SRAM data width DW = 8*DATA_BYTES.
- ADDR_W, 5, SRAM address width (1..16); ADDR_BYTES = ceil(ADDR_W/8).
- MSB_FIRST, 0, byte order on the serial link: 0 = least significant byte first, 1 = most significant byte first. Applies to data and to multi-byte addresses.
- TIMEOUT_CYC, 65535, maximum idle clocks between rx bytes inside a command; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data_out  in  8  received byte.
- rx_valid  in  1  received byte available.
- rx_ready  out  1  byte consumed this cycle when rx_valid && rx_ready.
- rx_enable  out  1  receiver enable.
- tx_ready  in  1  transmitter can accept a byte.
- tx_valid  out  1  byte offered on tx_data_in.
- tx_data_in  out  8  byte to transmit.
- tx_enable  out  1  transmitter enable.
- csb_n  out  1  SRAM chip select, active low.
- we_n  out  1  SRAM write enable, active low.
- addr  out  ADDR_W  SRAM address.
- sram_data_in  out  DW  SRAM write data.
- sram_data_out  in  DW  SRAM read data, valid one clock after a read strobe.
- busy  out  1  high whenever state != IDLE.
- abort  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset values: rx_ready=0, rx_enable=1, tx_valid=0, tx_data_in=0, tx_enable=0, csb_n=1, we_n=1, addr=0, sram_data_in=0, busy=0, abort=0, state=IDLE. All counters and shift registers clear.
- Reset mid-operation drops the transaction immediately. No SRAM strobe may be issued after rst_n falls.
- Command byte: bit7 = 1 read, 0 write. Bits[6:4] = burst length minus 1 (1..8 words). Bits[3:0] are ignored.
- After the command byte come ADDR_BYTES address bytes. Address bits above ADDR_W are discarded.
- rx handshake: a byte transfers only on a cycle with rx_valid && rx_ready. rx_ready is combinational and high only in CMD, ADDR and WDATA while rx_valid=1.
- tx handshake: tx_valid rises with tx_data_in stable and holds both until a cycle with tx_ready=1. The byte transfers on that cycle. tx_enable equals tx_valid.
- State IDLE/CMD: wait for the command byte, latch direction and burst length, go to ADDR.
- State ADDR: collect ADDR_BYTES bytes, then go to WDATA (write) or RREQ (read).
- State WDATA: shift in DATA_BYTES bytes, then go to WRITE.
- State WRITE: one cycle with csb_n=0, we_n=0, addr=current address, sram_data_in=assembled word.
- State RREQ: one cycle with csb_n=0, we_n=1, addr=current address.
- State RWAIT: one cycle; capture sram_data_out into a DW-bit holding register.
- State RSEND: transmit DATA_BYTES bytes in MSB_FIRST order.
- After WRITE or RSEND: if words remain, address += 1 (wraps from 2^ADDR_W-1 to 0) and return to WDATA or RREQ. Otherwise return to IDLE.
- SRAM strobes are registered outputs and are deasserted (csb_n=1, we_n=1) in every other state.
- Timeout: in ADDR or WDATA, an idle counter resets on each accepted byte. When it reaches TIMEOUT_CYC, go to IDLE, pulse abort, and perform no SRAM write.
- Timeout does not apply in IDLE or during tx, because tx back-pressure is unbounded.
- Read latency: the first tx_valid rises 3 cycles after the last address byte is accepted.

Test Plan:
- Single write then read, defaults: rx 0x00, 0x03, 0x11, 0x22, 0x33, 0x44 -> exactly one cycle with we_n=0, addr=3, sram_data_in=0x44332211. Then rx 0x80, 0x03 -> tx bytes 0x11, 0x22, 0x33, 0x44.
- Burst wrap, ADDR_W=5: write cmd 0x20 (3 words) at addr 0x1E -> writes to addresses 0x1E, 0x1F, 0x00. A read-back burst returns the same 12 bytes in order.
- Multi-byte address: ADDR_W=12, MSB_FIRST=1, DATA_BYTES=2, rx 0x00, 0x0A, 0xBC, 0xDE, 0xAD -> write at addr 0xABC with data 0xDEAD. A read returns tx 0xDE then 0xAD.
- tx back-pressure: hold tx_ready=0 for 50 cycles mid-read -> tx_valid and tx_data_in held stable, no byte lost or duplicated, busy=1 throughout.
- Timeout: TIMEOUT_CYC=10; send cmd 0x00, addr 0x05 and two data bytes, then go silent -> abort pulses once, no we_n=0 cycle, state returns to IDLE. The next command executes normally.
- Reset mid-burst: assert rst_n=0 during a 4-word write after word 1 -> all outputs return to reset values asynchronously and no further SRAM strobes occur.

Source files
------------

// File: rtl/sram_burst_bridge.sv
// Byte-stream to single-port SRAM bridge: rx command/address/data bytes drive
// burst writes or reads, and read data is returned byte by byte on the tx link.
module sram_burst_bridge #(
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned ADDR_W      = 5,
  parameter bit          MSB_FIRST   = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data_out,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    rx_enable,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data_in,
  output logic                    tx_enable,
  output logic                    csb_n,
  output logic                    we_n,
  output logic [ADDR_W-1:0]       addr,
  output logic [8*DATA_BYTES-1:0] sram_data_in,
  input  logic [8*DATA_BYTES-1:0] sram_data_out,
  output logic                    busy,
  output logic                    abort
);

  localparam int unsigned DW         = 8 * DATA_BYTES;
  localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned AB_W       = 8 * ADDR_BYTES;
  localparam int unsigned TO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RREQ, S_RWAIT, S_RSEND
  } state_t;

  state_t            state_q, state_d;
  logic              is_read_q, is_read_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        word_q, word_d;
  logic [2:0]        byte_q, byte_d;
  logic [AB_W-1:0]   abuf_q, abuf_d;
  logic [DW-1:0]     wbuf_q, wbuf_d;
  logic [DW-1:0]     rbuf_q, rbuf_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              tx_valid_d, csb_n_d, we_n_d, abort_d;
  logic [7:0]        tx_data_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DW-1:0]     sram_data_d;
  logic              timed_out, last_word;
  int                apos, dpos, npos;

  assign timed_out = (TIMEOUT_CYC != 0) && (idle_q == TO_W'(TIMEOUT_CYC - 1));
  assign last_word = (word_q == len_q);

  // Next-state and next-output logic; byte positions follow the link byte order
  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    len_d       = len_q;
    word_d      = word_q;
    byte_d      = byte_q;
    abuf_d      = abuf_q;
    wbuf_d      = wbuf_q;
    rbuf_d      = rbuf_q;
    idle_d      = '0;
    cur_addr_d  = cur_addr_q;
    tx_valid_d  = tx_valid;
    tx_data_d   = tx_data_in;
    abort_d     = 1'b0;
    addr_d      = addr;
    sram_data_d = sram_data_in;
    csb_n_d     = 1'b1;
    we_n_d      = 1'b1;
    rx_ready    = 1'b0;
    apos = MSB_FIRST ? int'(ADDR_BYTES) - 1 - int'(byte_q) : int'(byte_q);
    dpos = MSB_FIRST ? int'(DATA_BYTES) - 1 - int'(byte_q) : int'(byte_q);
    npos = MSB_FIRST ? int'(DATA_BYTES) - 2 - int'(byte_q) : int'(byte_q) + 1;

    case (state_q)
      S_IDLE: begin
        rx_ready = rx_valid;
        if (rx_valid) begin
          is_read_d = rx_data_out[7];
          len_d     = rx_data_out[6:4];
          word_d    = '0;
          byte_d    = '0;
          abuf_d    = '0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        rx_ready = rx_valid;
        if (rx_valid) begin
          for (int i = 0; i < int'(ADDR_BYTES); i++)
            if (i == apos) abuf_d[8*i +: 8] = rx_data_out;
          if (byte_q == 3'(ADDR_BYTES - 1)) begin
            byte_d     = '0;
            cur_addr_d = abuf_d[ADDR_W-1:0];
            state_d    = is_read_q ? S_RREQ : S_WDATA;
          end else begin
            byte_d = byte_q + 3'd1;
          end
        end else if (timed_out) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + TO_W'(1);
        end
      end
      S_WDATA: begin
        rx_ready = rx_valid;
        if (rx_valid) begin
          for (int i = 0; i < int'(DATA_BYTES); i++)
            if (i == dpos) wbuf_d[8*i +: 8] = rx_data_out;
          if (byte_q == 3'(DATA_BYTES - 1)) begin
            byte_d  = '0;
            state_d = S_WRITE;
          end else begin
            byte_d = byte_q + 3'd1;
          end
        end else if (timed_out) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + TO_W'(1);
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_IDLE;
        end else begin
          word_d     = word_q + 3'd1;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          state_d    = S_WDATA;
        end
      end
      S_RREQ:  state_d = S_RWAIT;
      S_RWAIT: begin
        rbuf_d     = sram_data_out;
        tx_valid_d = 1'b1;
        for (int i = 0; i < int'(DATA_BYTES); i++)
          if (i == dpos) tx_data_d = sram_data_out[8*i +: 8];
        state_d = S_RSEND;
      end
      S_RSEND: begin
        if (tx_valid && tx_ready) begin
          if (byte_q == 3'(DATA_BYTES - 1)) begin
            tx_valid_d = 1'b0;
            byte_d     = '0;
            if (last_word) begin
              state_d = S_IDLE;
            end else begin
              word_d     = word_q + 3'd1;
              cur_addr_d = cur_addr_q + ADDR_W'(1);
              state_d    = S_RREQ;
            end
          end else begin
            byte_d = byte_q + 3'd1;
            for (int i = 0; i < int'(DATA_BYTES); i++)
              if (i == npos) tx_data_d = rbuf_q[8*i +: 8];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the state being entered so they leave a flop
    csb_n_d = !(state_d == S_WRITE || state_d == S_RREQ);
    we_n_d  = (state_d != S_WRITE);
    if (!csb_n_d) addr_d = cur_addr_d;
    if (state_d == S_WRITE) sram_data_d = wbuf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      is_read_q    <= 1'b0;
      len_q        <= '0;
      word_q       <= '0;
      byte_q       <= '0;
      abuf_q       <= '0;
      wbuf_q       <= '0;
      rbuf_q       <= '0;
      idle_q       <= '0;
      cur_addr_q   <= '0;
      rx_enable    <= 1'b1;
      tx_valid     <= 1'b0;
      tx_enable    <= 1'b0;
      tx_data_in   <= '0;
      csb_n        <= 1'b1;
      we_n         <= 1'b1;
      addr         <= '0;
      sram_data_in <= '0;
      busy         <= 1'b0;
      abort        <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_read_q    <= is_read_d;
      len_q        <= len_d;
      word_q       <= word_d;
      byte_q       <= byte_d;
      abuf_q       <= abuf_d;
      wbuf_q       <= wbuf_d;
      rbuf_q       <= rbuf_d;
      idle_q       <= idle_d;
      cur_addr_q   <= cur_addr_d;
      rx_enable    <= 1'b1;
      tx_valid     <= tx_valid_d;
      tx_enable    <= tx_valid_d;
      tx_data_in   <= tx_data_d;
      csb_n        <= csb_n_d;
      we_n         <= we_n_d;
      addr         <= addr_d;
      sram_data_in <= sram_data_d;
      busy         <= (state_d != S_IDLE);
      abort        <= abort_d;
    end
  end

endmodule

// File: tb/tb_sram_burst_bridge.sv
// Scoreboard bench for sram_burst_bridge: two configurations, each with a
// behavioural SRAM, expected writes/tx bytes queued by stimulus, popped by monitors.
module tb_sram_burst_bridge;
  logic clk;
  logic rst_n;
  int   checks, failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Configuration A: 32-bit data, 5-bit address, LSB first, timeout 10
  logic [7:0]  a_rx_data, a_tx_data;
  logic        a_rx_valid, a_rx_ready, a_rx_enable, a_tx_ready, a_tx_valid, a_tx_enable;
  logic        a_csb_n, a_we_n, a_busy, a_abort;
  logic [4:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  // Configuration B: 16-bit data, 12-bit address, MSB first, no timeout
  logic [7:0]  b_rx_data, b_tx_data;
  logic        b_rx_valid, b_rx_ready, b_rx_enable, b_tx_ready, b_tx_valid, b_tx_enable;
  logic        b_csb_n, b_we_n, b_busy, b_abort;
  logic [11:0] b_addr;
  logic [15:0] b_wdata, b_rdata;

  sram_burst_bridge #(.DATA_BYTES(4), .ADDR_W(5), .MSB_FIRST(1'b0), .TIMEOUT_CYC(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data_out(a_rx_data), .rx_valid(a_rx_valid),
    .rx_ready(a_rx_ready), .rx_enable(a_rx_enable), .tx_ready(a_tx_ready),
    .tx_valid(a_tx_valid), .tx_data_in(a_tx_data), .tx_enable(a_tx_enable),
    .csb_n(a_csb_n), .we_n(a_we_n), .addr(a_addr), .sram_data_in(a_wdata),
    .sram_data_out(a_rdata), .busy(a_busy), .abort(a_abort));

  sram_burst_bridge #(.DATA_BYTES(2), .ADDR_W(12), .MSB_FIRST(1'b1), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data_out(b_rx_data), .rx_valid(b_rx_valid),
    .rx_ready(b_rx_ready), .rx_enable(b_rx_enable), .tx_ready(b_tx_ready),
    .tx_valid(b_tx_valid), .tx_data_in(b_tx_data), .tx_enable(b_tx_enable),
    .csb_n(b_csb_n), .we_n(b_we_n), .addr(b_addr), .sram_data_in(b_wdata),
    .sram_data_out(b_rdata), .busy(b_busy), .abort(b_abort));

  logic [31:0] mem_a [32];
  logic [15:0] mem_b [4096];

  always @(posedge clk) if (!a_csb_n) begin
    if (!a_we_n) mem_a[a_addr] <= a_wdata;
    else         a_rdata <= mem_a[a_addr];
  end
  always @(posedge clk) if (!b_csb_n) begin
    if (!b_we_n) mem_b[b_addr] <= b_wdata;
    else         b_rdata <= mem_b[b_addr];
  end

  int unsigned exp_wa[$], exp_wb[$];
  logic [31:0] exp_wd_a[$];
  logic [15:0] exp_wd_b[$];
  logic [7:0]  exp_tx_a[$], exp_tx_b[$];
  int a_wr_cnt, a_tx_cnt, a_strobes, a_aborts, b_wr_cnt, b_tx_cnt, b_aborts;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (!a_csb_n) a_strobes++;
    if (a_abort) a_aborts++;
    if (!a_csb_n && !a_we_n) begin
      a_wr_cnt++;
      check("a_wr_expected", 64'(exp_wa.size() != 0), 64'(1));
      if (exp_wa.size() != 0) begin
        check("a_wr_addr", 64'(a_addr), 64'(exp_wa.pop_front()));
        check("a_wr_data", 64'(a_wdata), 64'(exp_wd_a.pop_front()));
      end
    end
    if (a_tx_valid && a_tx_ready) begin
      a_tx_cnt++;
      check("a_tx_enable", 64'(a_tx_enable), 64'(1));
      check("a_tx_expected", 64'(exp_tx_a.size() != 0), 64'(1));
      if (exp_tx_a.size() != 0) check("a_tx_byte", 64'(a_tx_data), 64'(exp_tx_a.pop_front()));
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (b_abort) b_aborts++;
    if (!b_csb_n && !b_we_n) begin
      b_wr_cnt++;
      check("b_wr_expected", 64'(exp_wb.size() != 0), 64'(1));
      if (exp_wb.size() != 0) begin
        check("b_wr_addr", 64'(b_addr), 64'(exp_wb.pop_front()));
        check("b_wr_data", 64'(b_wdata), 64'(exp_wd_b.pop_front()));
      end
    end
    if (b_tx_valid && b_tx_ready) begin
      b_tx_cnt++;
      check("b_tx_expected", 64'(exp_tx_b.size() != 0), 64'(1));
      if (exp_tx_b.size() != 0) check("b_tx_byte", 64'(b_tx_data), 64'(exp_tx_b.pop_front()));
    end
  end

  task automatic exp_wr(input bit sel, input int unsigned ad, input logic [31:0] d);
    if (sel) begin exp_wb.push_back(ad); exp_wd_b.push_back(d[15:0]); end
    else     begin exp_wa.push_back(ad); exp_wd_a.push_back(d); end
  endtask

  task automatic exp_tx(input bit sel, input logic [7:0] v);
    if (sel) exp_tx_b.push_back(v);
    else     exp_tx_a.push_back(v);
  endtask

  task automatic send(input bit sel, input logic [7:0] v);
    if (sel) begin b_rx_data = v; b_rx_valid = 1'b1; end
    else     begin a_rx_data = v; a_rx_valid = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel ? b_rx_ready : a_rx_ready) begin
        @(posedge clk); #1;
        a_rx_valid = 1'b0;
        b_rx_valid = 1'b0;
        return;
      end
    end
    check("rx_accept", 64'(sel ? b_rx_ready : a_rx_ready), 64'(1));
    a_rx_valid = 1'b0;
    b_rx_valid = 1'b0;
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0: return a_wr_cnt;
      1: return a_tx_cnt;
      2: return b_wr_cnt;
      default: return b_tx_cnt;
    endcase
  endfunction

  task automatic wait_cnt(input string name, input int which, input int target);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (cnt_of(which) >= target) return;
    end
    check(name, 64'(cnt_of(which)), 64'(target));
  endtask

  task automatic wait_idle(input string name, input bit sel);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!(sel ? b_busy : a_busy)) break;
    end
    check(name, 64'(sel ? b_busy : a_busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int s0, good;
    logic [7:0] d0;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    a_rx_data = '0; a_rx_valid = 1'b0; a_tx_ready = 1'b1; a_rdata = '0;
    b_rx_data = '0; b_rx_valid = 1'b0; b_tx_ready = 1'b1; b_rdata = '0;
    for (int i = 0; i < 32; i++) mem_a[i] = '0;
    for (int i = 0; i < 4096; i++) mem_b[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    // {rx_ready,rx_enable,tx_valid,tx_enable,csb_n,we_n,busy,abort}
    check("rst_a_ctrl", 64'({a_rx_ready, a_rx_enable, a_tx_valid, a_tx_enable, a_csb_n, a_we_n, a_busy, a_abort}), 64'(8'h4C));
    check("rst_a_bus", 64'({a_addr, a_wdata, a_tx_data}), 64'(0));
    check("rst_b_ctrl", 64'({b_rx_ready, b_rx_enable, b_tx_valid, b_tx_enable, b_csb_n, b_we_n, b_busy, b_abort}), 64'(8'h4C));
    check("rst_b_bus", 64'({b_addr, b_wdata, b_tx_data}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A: single write then read with latency check
    exp_wr(0, 3, 32'h44332211);
    send(0, 8'h00); send(0, 8'h03); send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
    wait_cnt("a_t1_write", 0, 1);
    wait_idle("a_t1_write_idle", 0);
    check("a_t1_one_write", 64'(a_wr_cnt), 64'(1));
    exp_tx(0, 8'h11); exp_tx(0, 8'h22); exp_tx(0, 8'h33); exp_tx(0, 8'h44);
    send(0, 8'h80); send(0, 8'h03);
    @(posedge clk); #1;
    check("a_rd_latency_early", 64'(a_tx_valid), 64'(0));
    @(posedge clk); #1;
    check("a_rd_latency", 64'(a_tx_valid), 64'(1));
    wait_cnt("a_t1_read", 1, 4);
    wait_idle("a_t1_read_idle", 0);

    // A: 3-word burst wrapping 0x1E -> 0x1F -> 0x00, read back with back-pressure
    exp_wr(0, 5'h1E, 32'h04030201); exp_wr(0, 5'h1F, 32'h08070605); exp_wr(0, 5'h00, 32'h0C0B0A09);
    send(0, 8'h20); send(0, 8'h1E);
    for (int i = 1; i <= 12; i++) send(0, 8'(i));
    wait_cnt("a_t2_write", 0, 4);
    wait_idle("a_t2_write_idle", 0);
    for (int i = 1; i <= 12; i++) exp_tx(0, 8'(i));
    send(0, 8'hA0); send(0, 8'h1E);
    wait_cnt("a_t2_first_bytes", 1, 6);
    a_tx_ready = 1'b0;
    a_rx_valid = 1'b1;
    a_rx_data  = 8'h00;
    d0 = a_tx_data;
    good = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_tx_valid && a_tx_data == d0 && a_busy && !a_rx_ready) good++;
    end
    @(posedge clk); #1;
    a_rx_valid = 1'b0;
    a_tx_ready = 1'b1;
    check("a_bp_held_cycles", 64'(good), 64'(50));
    check("a_bp_byte", 64'(d0), 64'(8'h03));
    wait_cnt("a_t2_read", 1, 16);
    wait_idle("a_t2_read_idle", 0);

    // A: inter-byte timeout in WDATA, then a normal command
    send(0, 8'h00); send(0, 8'h05); send(0, 8'hAA); send(0, 8'hBB);
    repeat (9) @(posedge clk);
    #1;
    check("a_to_before", 64'({a_busy, a_abort}), 64'(2'b10));
    @(posedge clk); #1;
    check("a_to_abort", 64'({a_busy, a_abort}), 64'(2'b01));
    repeat (5) @(posedge clk);
    #1;
    check("a_to_abort_count", 64'(a_aborts), 64'(1));
    check("a_to_no_write", 64'(a_wr_cnt), 64'(4));
    exp_wr(0, 5, 32'hCAFEF00D);
    send(0, 8'h00); send(0, 8'h05); send(0, 8'h0D); send(0, 8'hF0); send(0, 8'hFE); send(0, 8'hCA);
    wait_cnt("a_t3_write", 0, 5);
    exp_tx(0, 8'h0D); exp_tx(0, 8'hF0); exp_tx(0, 8'hFE); exp_tx(0, 8'hCA);
    send(0, 8'h80); send(0, 8'h05);
    wait_cnt("a_t3_read", 1, 20);
    wait_idle("a_t3_idle", 0);

    // A: reset during second word of a 4-word write
    exp_wr(0, 8, 32'h11223344);
    send(0, 8'h30); send(0, 8'h08); send(0, 8'h44); send(0, 8'h33); send(0, 8'h22); send(0, 8'h11);
    wait_cnt("a_t4_write", 0, 6);
    send(0, 8'h55); send(0, 8'h66);
    #1;
    s0 = a_strobes;
    rst_n = 1'b0;
    #1;
    check("a_mid_rst_ctrl", 64'({a_rx_ready, a_rx_enable, a_tx_valid, a_tx_enable, a_csb_n, a_we_n, a_busy, a_abort}), 64'(8'h4C));
    check("a_mid_rst_bus", 64'({a_addr, a_wdata, a_tx_data}), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("a_no_strobe_after_rst", 64'(a_strobes), 64'(s0));
    check("a_idle_after_rst", 64'(a_busy), 64'(0));
    exp_tx(0, 8'h44); exp_tx(0, 8'h33); exp_tx(0, 8'h22); exp_tx(0, 8'h11);
    send(0, 8'h80); send(0, 8'h08);
    wait_cnt("a_t4_read", 1, 24);
    wait_idle("a_t4_idle", 0);

    // B: two address bytes, MSB-first data
    exp_wr(1, 12'hABC, 32'h0000DEAD);
    send(1, 8'h00); send(1, 8'h0A); send(1, 8'hBC); send(1, 8'hDE); send(1, 8'hAD);
    wait_cnt("b_t1_write", 2, 1);
    exp_tx(1, 8'hDE); exp_tx(1, 8'hAD);
    send(1, 8'h80); send(1, 8'h0A); send(1, 8'hBC);
    wait_cnt("b_t1_read", 3, 2);
    wait_idle("b_t1_idle", 1);

    // B: 2-word burst wrapping 0xFFF -> 0x000
    exp_wr(1, 12'hFFF, 32'h00001234); exp_wr(1, 12'h000, 32'h00005678);
    send(1, 8'h10); send(1, 8'h0F); send(1, 8'hFF);
    send(1, 8'h12); send(1, 8'h34); send(1, 8'h56); send(1, 8'h78);
    wait_cnt("b_t2_write", 2, 3);
    exp_tx(1, 8'h12); exp_tx(1, 8'h34); exp_tx(1, 8'h56); exp_tx(1, 8'h78);
    send(1, 8'h90); send(1, 8'h0F); send(1, 8'hFF);
    wait_cnt("b_t2_read", 3, 6);
    wait_idle("b_t2_idle", 1);

    // B: upper address bits discarded; long gap with timeout disabled
    exp_wr(1, 12'h123, 32'h0000BEEF);
    send(1, 8'h00); send(1, 8'hF1); send(1, 8'h23); send(1, 8'hBE);
    repeat (100) @(posedge clk);
    #1;
    check("b_gap_busy", 64'(b_busy), 64'(1));
    send(1, 8'hEF);
    wait_cnt("b_t3_write", 2, 4);
    wait_idle("b_t3_idle", 1);
    check("b_no_abort", 64'(b_aborts), 64'(0));

    check("a_total_writes", 64'(a_wr_cnt), 64'(6));
    check("a_total_tx", 64'(a_tx_cnt), 64'(24));
    check("b_total_writes", 64'(b_wr_cnt), 64'(4));
    check("b_total_tx", 64'(b_tx_cnt), 64'(6));
    check("a_exp_left", 64'(exp_wa.size() + exp_tx_a.size()), 64'(0));
    check("b_exp_left", 64'(exp_wb.size() + exp_tx_b.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
